// File: rtl/beaver32rv_mc.sv
`timescale 1ns/1ps
// beaver32rv_mc: multi-cycle RV32I core with a single unified memory port.
// Sequence is FETCH -> DECODE -> EXECUTE -> (MEM) -> WB, with HALT as the
// absorbing state for traps, ECALL/EBREAK and misaligned control transfers.
// Optional build macro: BEAVER32RV_PERF_COUNTERS_EN adds 64-bit cycle and
// retired-instruction counters.
//
// Memory handshake: a transfer starts when mem_req_o is high and completes
// in the first cycle where mem_ready_i is also high. mem_addr_o, mem_we_o
// and mem_wdata_o are held stable from the rise of mem_req_o until that
// cycle; mem_req_o drops in the cycle after. mem_ready_i without mem_req_o
// has no effect.
module beaver32rv_mc #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          ADDR_WIDTH   = 32,
  parameter int          NUM_REGS     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  input  logic [31:0]           mem_rdata_i,
  input  logic                  mem_ready_i,
  output logic [31:0]           pc_o,
  output logic                  retire_o,
  output logic                  halted_o,
  output logic [2:0]            state_o
`ifdef BEAVER32RV_PERF_COUNTERS_EN
  ,
  output logic [63:0]           cycle_count_o,
  output logic [63:0]           instret_count_o
`endif
);

  localparam int         RIDX_W = $clog2(NUM_REGS);
  localparam logic [5:0] NREG   = 6'(NUM_REGS);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_HALT
  } state_t;

  state_t      state_q, state_d;
  logic        hold_q;  // set while in reset, keeps the first fetch quiet
  logic [31:0] pc_q, ir_q, a_q, b_q, imm_q, res_q, npc_q;
  logic [31:0] rf_q [NUM_REGS];

  // Instruction fields
  logic [6:0] opcode, funct7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;
  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign funct3 = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign funct7 = ir_q[31:25];

  // Decode: legality, register usage and immediate selection
  logic        legal, use_rd, use_rs1, use_rs2, dec_trap;
  logic [31:0] dec_imm;
  always_comb begin
    legal   = 1'b0;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    dec_imm = '0;
    case (opcode)
      OP_LUI, OP_AUIPC: begin
        legal = 1'b1; use_rd = 1'b1; dec_imm = {ir_q[31:12], 12'b0};
      end
      OP_JAL: begin
        legal = 1'b1; use_rd = 1'b1;
        dec_imm = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
      end
      OP_JALR: begin
        legal = (funct3 == 3'b000); use_rd = 1'b1; use_rs1 = 1'b1;
        dec_imm = {{20{ir_q[31]}}, ir_q[31:20]};
      end
      OP_BRANCH: begin
        legal = (funct3 != 3'b010) && (funct3 != 3'b011);
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        dec_imm = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
      end
      OP_LOAD: begin
        legal = (funct3 == 3'b010); use_rd = 1'b1; use_rs1 = 1'b1;
        dec_imm = {{20{ir_q[31]}}, ir_q[31:20]};
      end
      OP_STORE: begin
        legal = (funct3 == 3'b010); use_rs1 = 1'b1; use_rs2 = 1'b1;
        dec_imm = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      end
      OP_IMM: begin
        if (funct3 == 3'b001)      legal = (funct7 == 7'b0000000);
        else if (funct3 == 3'b101) legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
        else                       legal = 1'b1;
        use_rd = 1'b1; use_rs1 = 1'b1;
        dec_imm = {{20{ir_q[31]}}, ir_q[31:20]};
      end
      OP_REG: begin
        legal = (funct7 == 7'b0000000) ||
                ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      default: legal = 1'b0;  // includes ECALL/EBREAK and every SYSTEM op
    endcase
    dec_trap = !legal ||
               (use_rd  && ({1'b0, rd}  >= NREG)) ||
               (use_rs1 && ({1'b0, rs1} >= NREG)) ||
               (use_rs2 && ({1'b0, rs2} >= NREG));
  end

  // Execute: ALU, branch resolution and next-PC selection
  logic [31:0] op_b, alu, exec_res, target, exec_npc;
  logic        taken, redirect, exec_trap;
  always_comb begin
    op_b = ((opcode == OP_REG) || (opcode == OP_BRANCH)) ? b_q : imm_q;
    case (funct3)
      3'b000:  alu = ((opcode == OP_REG) && ir_q[30]) ? a_q - op_b : a_q + op_b;
      3'b001:  alu = a_q << op_b[4:0];
      3'b010:  alu = {31'b0, $signed(a_q) < $signed(op_b)};
      3'b011:  alu = {31'b0, a_q < op_b};
      3'b100:  alu = a_q ^ op_b;
      3'b101:  alu = ir_q[30] ? $unsigned($signed(a_q) >>> op_b[4:0]) : a_q >> op_b[4:0];
      3'b110:  alu = a_q | op_b;
      default: alu = a_q & op_b;
    endcase
    case (funct3)
      3'b000:  taken = (a_q == b_q);
      3'b001:  taken = (a_q != b_q);
      3'b100:  taken = $signed(a_q) <  $signed(b_q);
      3'b101:  taken = $signed(a_q) >= $signed(b_q);
      3'b110:  taken = a_q <  b_q;
      default: taken = a_q >= b_q;
    endcase
    case (opcode)
      OP_LUI:            exec_res = imm_q;
      OP_AUIPC:          exec_res = pc_q + imm_q;
      OP_JAL, OP_JALR:   exec_res = pc_q + 32'd4;
      OP_LOAD, OP_STORE: exec_res = a_q + imm_q;
      default:           exec_res = alu;
    endcase
    target    = (opcode == OP_JALR) ? ((a_q + imm_q) & 32'hFFFF_FFFE) : pc_q + imm_q;
    redirect  = (opcode == OP_JAL) || (opcode == OP_JALR) || ((opcode == OP_BRANCH) && taken);
    exec_npc  = redirect ? target : pc_q + 32'd4;
    exec_trap = redirect && target[1];
  end

  // FSM next state and memory port drive
  always_comb begin
    state_d     = state_q;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state_q)
      S_FETCH: if (!hold_q) begin
        mem_req_o  = 1'b1;
        mem_addr_o = {pc_q[ADDR_WIDTH-1:2], 2'b00};
        if (mem_ready_i) state_d = S_DECODE;
      end
      S_DECODE:  state_d = dec_trap ? S_HALT : S_EXECUTE;
      S_EXECUTE: begin
        if (exec_trap)                                     state_d = S_HALT;
        else if ((opcode == OP_LOAD) || (opcode == OP_STORE)) state_d = S_MEM;
        else                                               state_d = S_WB;
      end
      S_MEM: begin
        mem_req_o   = 1'b1;
        mem_we_o    = (opcode == OP_STORE);
        mem_addr_o  = {res_q[ADDR_WIDTH-1:2], 2'b00};
        mem_wdata_o = (opcode == OP_STORE) ? b_q : 32'd0;
        if (mem_ready_i) state_d = S_WB;
      end
      S_WB:    state_d = S_FETCH;
      default: state_d = S_HALT;
    endcase
  end

  assign pc_o     = pc_q;
  assign retire_o = (state_q == S_WB);
  assign halted_o = (state_q == S_HALT);
  assign state_o  = state_q;

  // State register and reset hold flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_FETCH;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      hold_q  <= 1'b0;
    end
  end

  // Datapath registers and register file
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q  <= RESET_VECTOR;
      ir_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      imm_q <= '0;
      res_q <= '0;
      npc_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else begin
      case (state_q)
        S_FETCH: if (!hold_q && mem_ready_i) ir_q <= mem_rdata_i;
        S_DECODE: begin
          a_q   <= rf_q[rs1[RIDX_W-1:0]];
          b_q   <= rf_q[rs2[RIDX_W-1:0]];
          imm_q <= dec_imm;
        end
        S_EXECUTE: begin
          res_q <= exec_res;
          npc_q <= exec_npc;
        end
        S_MEM: if (mem_ready_i && (opcode == OP_LOAD)) res_q <= mem_rdata_i;
        S_WB: begin
          if ((opcode != OP_BRANCH) && (opcode != OP_STORE) && (rd != 5'd0))
            rf_q[rd[RIDX_W-1:0]] <= res_q;
          pc_q <= npc_q;
        end
        default: ;
      endcase
    end
  end

`ifdef BEAVER32RV_PERF_COUNTERS_EN
  logic [63:0] cycle_q, instret_q;
  // Free-running cycle counter and retired-instruction counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q <= cycle_q + 64'd1;
      if (retire_o) instret_q <= instret_q + 64'd1;
    end
  end
  assign cycle_count_o   = cycle_q;
  assign instret_count_o = instret_q;
`endif

endmodule

// File: tb/tb_beaver32rv_mc.sv
`timescale 1ns/1ps
// Bench for beaver32rv_mc: directed programs against a behavioural memory
// with programmable wait states; results are stored back to memory.
module tb_beaver32rv_mc;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  logic        mem_req_o, mem_we_o, mem_ready_i, retire_o, halted_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i, pc_o;
  logic [2:0]  state_o;
`ifdef BEAVER32RV_PERF_COUNTERS_EN
  logic [63:0] cycle_count, instret_count;
`endif

  beaver32rv_mc #(.RESET_VECTOR(32'h100), .ADDR_WIDTH(32), .NUM_REGS(32)) dut (
    .clk(clk), .rst(rst),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i),
    .pc_o(pc_o), .retire_o(retire_o), .halted_o(halted_o), .state_o(state_o)
`ifdef BEAVER32RV_PERF_COUNTERS_EN
    , .cycle_count_o(cycle_count), .instret_count_o(instret_count)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Instruction encoders
  function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, int op);
    logic [31:0] im, a, f, d, o;
    im = imm; a = rs1; f = f3; d = rd; o = op;
    return {im[11:0], a[4:0], f[2:0], d[4:0], o[6:0]};
  endfunction
  function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
    logic [31:0] s, b, a, f, d;
    s = f7; b = rs2; a = rs1; f = f3; d = rd;
    return {s[6:0], b[4:0], a[4:0], f[2:0], d[4:0], 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_s(int imm, int rs2, int rs1);
    logic [31:0] im, b, a;
    im = imm; b = rs2; a = rs1;
    return {im[11:5], b[4:0], a[4:0], 3'b010, im[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
    logic [31:0] im, b, a, f;
    im = imm; b = rs2; a = rs1; f = f3;
    return {im[12], im[10:5], b[4:0], a[4:0], f[2:0], im[4:1], im[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(int imm, int rd);
    logic [31:0] im, d;
    im = imm; d = rd;
    return {im[20], im[10:1], im[11], im[19:12], d[4:0], 7'b1101111};
  endfunction
  function automatic logic [31:0] enc_u(int imm20, int rd, int op);
    logic [31:0] im, d, o;
    im = imm20; d = rd; o = op;
    return {im[19:0], d[4:0], o[6:0]};
  endfunction

  localparam int OPI = 7'b0010011;
  localparam logic [31:0] ECALL = 32'h0000_0073;

  // Memory model and observation queues
  logic [31:0] mem [0:255];
  int          wait_cycles = 0;
  int          retire_cyc[$];
  int          rd_cyc[$];
  logic [31:0] rd_addr_q[$];
  logic [31:0] st_addr_q[$];
  logic [31:0] st_data_q[$];
  logic [31:0] exp_q[$];
  int          halt_cyc = -1;
  int          req_seen = 0;

  // Driver: memory responder with wait states, plus retire/halt monitor
  initial begin : responder
    int          wcnt;
    logic [31:0] f_addr, f_wdata;
    logic        f_we, unstable;
    logic [7:0]  idx;
    wcnt = 0; unstable = 1'b0; f_addr = '0; f_wdata = '0; f_we = 1'b0;
    mem_ready_i = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      if (retire_o === 1'b1) retire_cyc.push_back(cyc);
      if (halted_o === 1'b1 && halt_cyc < 0) halt_cyc = cyc;
      if (mem_req_o === 1'b1) begin
        req_seen++;
        if (wcnt == 0) begin
          f_addr = mem_addr_o; f_we = mem_we_o; f_wdata = mem_wdata_o; unstable = 1'b0;
        end else if (mem_addr_o !== f_addr || mem_we_o !== f_we || mem_wdata_o !== f_wdata) begin
          unstable = 1'b1;
        end
        if (wcnt >= wait_cycles) begin
          mem_ready_i = 1'b1;
          idx = mem_addr_o[9:2];
          if (mem_we_o) begin
            mem[idx] = mem_wdata_o;
            st_addr_q.push_back(mem_addr_o);
            st_data_q.push_back(mem_wdata_o);
          end else begin
            mem_rdata_i = mem[idx];
            rd_addr_q.push_back(mem_addr_o);
            rd_cyc.push_back(cyc);
          end
          if (wait_cycles > 0) check("hs_stable", {63'b0, unstable}, 64'd0);
          wcnt = 0;
        end else begin
          mem_ready_i = 1'b0;
          mem_rdata_i = 32'hDEAD_BEEF;
          wcnt++;
        end
      end else begin
        mem_ready_i = 1'b0;
        wcnt = 0;
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  endtask

  task automatic put(input logic [31:0] addr, input logic [31:0] instr);
    logic [7:0] idx;
    idx = addr[9:2];
    mem[idx] = instr;
  endtask

  task automatic assert_reset();
    @(negedge clk);
    rst = 1'b0;
    retire_cyc.delete(); rd_cyc.delete(); rd_addr_q.delete();
    st_addr_q.delete(); st_data_q.delete();
    halt_cyc = -1;
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_to_halt(input string tag, input int budget);
    int n;
    n = 0;
    rst = 1'b1;
    while (halted_o !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, {63'b0, halted_o}, 64'd1);
  endtask

  function automatic logic [31:0] rd_mem(input logic [31:0] addr);
    logic [7:0] idx;
    idx = addr[9:2];
    return mem[idx];
  endfunction

  initial begin : main
    int regs[15];
    int base_req, n_ret;
`ifdef BEAVER32RV_PERF_COUNTERS_EN
    logic [63:0] c0;
`endif
    regs = '{0, 2, 3, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16};

    // ---- ALU chain, zero-wait memory, also covers reset behaviour ----
    clear_mem();
    put(32'h100, enc_i(5, 0, 0, 1, OPI));           // addi x1,x0,5
    put(32'h104, enc_i(-7, 1, 0, 2, OPI));          // addi x2,x1,-7
    put(32'h108, enc_r(0, 2, 1, 3, 3));             // sltu x3,x1,x2
    put(32'h10C, enc_r(32, 2, 1, 0, 7));            // sub  x7,x1,x2
    put(32'h110, enc_r(32, 1, 2, 5, 5));            // sra  x5,x2,x1
    put(32'h114, enc_r(0, 1, 2, 5, 6));             // srl  x6,x2,x1
    put(32'h118, enc_r(0, 2, 1, 4, 8));             // xor  x8,x1,x2
    put(32'h11C, enc_r(0, 1, 2, 2, 9));             // slt  x9,x2,x1
    put(32'h120, enc_r(0, 1, 1, 1, 10));            // sll  x10,x1,x1
    put(32'h124, enc_r(0, 2, 1, 7, 11));            // and  x11,x1,x2
    put(32'h128, enc_r(0, 2, 1, 6, 12));            // or   x12,x1,x2
    put(32'h12C, enc_u(32'h12345, 13, 7'b0110111)); // lui  x13,0x12345
    put(32'h130, enc_u(1, 14, 7'b0010111));         // auipc x14,0x1
    put(32'h134, enc_i(-1, 2, 2, 15, OPI));         // slti x15,x2,-1
    put(32'h138, enc_i(32'h401, 2, 5, 16, OPI));    // srai x16,x2,1
    put(32'h13C, enc_i(9, 1, 0, 0, OPI));           // addi x0,x1,9
    for (int k = 0; k < 15; k++)
      put(32'h140 + 32'(4 * k), enc_s(32'h300 + 4 * k, regs[k], 0));
    put(32'h17C, ECALL);
    exp_q = '{32'h0, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFF, 32'h07FF_FFFF, 32'h7,
              32'hFFFF_FFFB, 32'h1, 32'hA0, 32'h4, 32'hFFFF_FFFF, 32'h1234_5000,
              32'h1130, 32'h1, 32'hFFFF_FFFF};
    wait_cycles = 0;
    assert_reset();
    check("rst_req", {63'b0, mem_req_o}, 64'd0);
    check("rst_pc", {32'b0, pc_o}, 64'h100);
    check("rst_addr", {32'b0, mem_addr_o}, 64'd0);
    check("rst_we", {63'b0, mem_we_o}, 64'd0);
    check("rst_wdata", {32'b0, mem_wdata_o}, 64'd0);
    check("rst_retire", {63'b0, retire_o}, 64'd0);
    check("rst_halted", {63'b0, halted_o}, 64'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("first_req", {63'b0, mem_req_o}, 64'd1);
    check("first_addr", {32'b0, mem_addr_o}, 64'h100);
    check("first_we", {63'b0, mem_we_o}, 64'd0);
    run_to_halt("alu_halt", 2000);
    for (int k = 0; k < 15; k++)
      check($sformatf("alu_x%0d", regs[k]), {32'b0, rd_mem(32'h300 + 32'(4 * k))}, {32'b0, exp_q[k]});
    check("alu_nret", 64'(retire_cyc.size()), 64'd31);
    if (retire_cyc.size() >= 17) begin
      check("alu_gap0", 64'(retire_cyc[1] - retire_cyc[0]), 64'd4);
      check("alu_gap1", 64'(retire_cyc[2] - retire_cyc[1]), 64'd4);
      check("sw_gap", 64'(retire_cyc[16] - retire_cyc[15]), 64'd5);
    end
`ifdef BEAVER32RV_PERF_COUNTERS_EN
    check("alu_instret", instret_count, 64'd31);
`endif

    // ---- Store/load with 3 wait cycles per transfer ----
    clear_mem();
    put(32'h100, enc_i(-2, 0, 0, 2, OPI));          // addi x2,x0,-2
    put(32'h104, enc_s(8, 2, 0));                   // sw x2,8(x0)
    put(32'h108, enc_i(8, 0, 2, 4, 7'b0000011));    // lw x4,8(x0)
    put(32'h10C, enc_s(32'h88, 4, 0));              // sw x4,0x88(x0)
    put(32'h110, ECALL);
    wait_cycles = 3;
    assert_reset();
    run_to_halt("ls_halt", 2000);
    check("ls_nstore", 64'(st_addr_q.size()), 64'd2);
    if (st_addr_q.size() >= 1) begin
      check("sw_addr", {32'b0, st_addr_q[0]}, 64'h8);
      check("sw_wdata", {32'b0, st_data_q[0]}, 64'hFFFF_FFFE);
    end
    check("lw_x4", {32'b0, rd_mem(32'h88)}, 64'hFFFF_FFFE);
    if (retire_cyc.size() >= 3) begin
      check("sw_cycles", 64'(retire_cyc[1] - retire_cyc[0]), 64'd11);
      check("lw_cycles", 64'(retire_cyc[2] - retire_cyc[1]), 64'd11);
    end
    wait_cycles = 0;

    // ---- Branches: blt taken backwards, bltu not taken, beq taken ----
    for (int pass = 0; pass < 2; pass++) begin
      clear_mem();
      put(32'h100, enc_i(-1, 0, 0, 1, OPI));        // addi x1,x0,-1
      put(32'h104, enc_i(1, 0, 0, 2, OPI));         // addi x2,x0,1
      put(32'h108, enc_j(-32'hC8, 0));              // jal x0,0x40
      put(32'h40, enc_b(-8, 2, 1, (pass == 0) ? 4 : 6)); // blt / bltu x1,x2,-8
      put(32'h44, enc_b(8, 1, 1, 0));               // beq x1,x1,+8
      put(32'h38, ECALL);
      put(32'h48, ECALL);
      put(32'h4C, ECALL);
      assert_reset();
      run_to_halt("br_halt", 2000);
      if (pass == 0) begin
        check("blt_n", 64'(rd_addr_q.size()), 64'd5);
        if (rd_addr_q.size() >= 5) check("blt_next", {32'b0, rd_addr_q[4]}, 64'h38);
      end else begin
        check("bltu_n", 64'(rd_addr_q.size()), 64'd6);
        if (rd_addr_q.size() >= 6) begin
          check("bltu_next", {32'b0, rd_addr_q[4]}, 64'h44);
          check("beq_next", {32'b0, rd_addr_q[5]}, 64'h4C);
        end
      end
    end

    // ---- Jumps: jal links and redirects, misaligned jalr traps ----
    clear_mem();
    put(32'h100, enc_j(-32'hE0, 0));                // jal x0,0x20
    put(32'h20, enc_j(16, 1));                      // jal x1,+16
    put(32'h24, ECALL);
    put(32'h30, enc_s(32'h80, 1, 0));               // sw x1,0x80(x0)
    put(32'h34, enc_i(32'h55, 0, 0, 5, OPI));       // addi x5,x0,0x55
    put(32'h38, enc_i(3, 1, 0, 5, 7'b1100111));     // jalr x5,3(x1)
    put(32'h3C, ECALL);
    assert_reset();
    run_to_halt("jmp_halt", 2000);
    check("jal_link", {32'b0, rd_mem(32'h80)}, 64'h24);
    check("jmp_nfetch", 64'(rd_addr_q.size()), 64'd5);
    if (rd_addr_q.size() >= 3) check("jal_target", {32'b0, rd_addr_q[2]}, 64'h30);
    check("jalr_noret", 64'(retire_cyc.size()), 64'd4);
    base_req = req_seen;
    repeat (10) @(negedge clk);
    check("jmp_quiet", 64'(req_seen - base_req), 64'd0);
    check("jmp_sticky", {63'b0, halted_o}, 64'd1);

    // ---- Illegal instruction 0x0000_0000 ----
    clear_mem();
    assert_reset();
    run_to_halt("ill_halt", 2000);
    if (rd_cyc.size() >= 1) check("ill_latency", 64'(halt_cyc - rd_cyc[0]), 64'd2);
    base_req = req_seen;
    n_ret = retire_cyc.size();
`ifdef BEAVER32RV_PERF_COUNTERS_EN
    c0 = cycle_count;
`endif
    repeat (10) @(negedge clk);
    check("ill_noret", 64'(retire_cyc.size()), 64'd0);
    check("ill_noret_late", 64'(retire_cyc.size() - n_ret), 64'd0);
    check("ill_quiet", 64'(req_seen - base_req), 64'd0);
    check("ill_sticky", {63'b0, halted_o}, 64'd1);
`ifdef BEAVER32RV_PERF_COUNTERS_EN
    check("ill_instret", instret_count, 64'd0);
    check("ill_cycles", cycle_count - c0, 64'd10);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
